// File: rtl/amux_scan_ctrl.sv
// Analog mux channel sequencer: static select or round-robin scan with programmable dwell.
// Define AMUX_SCAN_BBM_EN to insert DEAD_CYCLES all-off cycles between channels.
module amux_scan_ctrl #(
  parameter int unsigned DWELL_SHIFT = 2,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  input  logic [7:0] scan_mask,
  output logic [7:0] amux_en,
  output logic [7:0] amux_en_neg,
  output logic       busy,
  output logic [2:0] ch_idx,
  output logic       ch_done,
  output logic       scan_wrap
);

  localparam int unsigned DW = 6 + DWELL_SHIFT;
`ifdef AMUX_SCAN_BBM_EN
  localparam bit BBM_EN = 1'b1;
`else
  localparam bit BBM_EN = 1'b0;
`endif
  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEAD, ON_STATIC, ON_SCAN} state_t;
  typedef enum logic [1:0] {OP_STOP, OP_SELECT, OP_SET_DWELL, OP_SCAN} op_t;

  state_t          state, state_n;
  op_t             op;
  logic [7:0]      dead_cnt, dead_n;
  logic [DW-1:0]   dwell_cnt, dwell_n, dwell_load;
  logic [5:0]      dwell_code, code_n;
  logic [7:0]      mask, mask_n;
  logic [2:0]      ch_n, pend_ch, pend_ch_n, sw_ch, enter_ch;
  logic            pend_scan, pend_scan_n, sw_scan, enter_scan;
  logic            switch_req, enter_req;
  logic [7:0]      en_n;
  logic            done_n, wrap_n;

  assign op = op_t'(cmd_data[7:6]);

  // Next set mask bit strictly above c, wrapping; returns c itself for a single-bit mask.
  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] c);
    logic [2:0] r;
    logic [2:0] k;
    logic       found;
    r     = c;
    found = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      k = 3'(c + i);
      if (!found && m[k]) begin
        r     = k;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] high_bit(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  always_comb begin
    state_n     = state;
    dead_n      = dead_cnt;
    dwell_n     = dwell_cnt;
    code_n      = dwell_code;
    mask_n      = mask;
    ch_n        = ch_idx;
    pend_ch_n   = pend_ch;
    pend_scan_n = pend_scan;
    switch_req  = 1'b0;
    enter_req   = 1'b0;
    sw_ch       = ch_idx;
    sw_scan     = 1'b0;
    enter_ch    = pend_ch;
    enter_scan  = pend_scan;

    unique case (state)
      DEAD:
        if (dead_cnt == '0) enter_req = 1'b1;
        else                dead_n    = dead_cnt - 8'd1;
      ON_SCAN:
        if (dwell_cnt == '0) begin
          switch_req = 1'b1;
          sw_ch      = next_set(mask, ch_idx);
          sw_scan    = 1'b1;
        end else begin
          dwell_n = dwell_cnt - DW'(1);
        end
      default: ;
    endcase

    // A command overrides the natural gap expiry / scan advance, except SET_DWELL.
    if (cmd_valid) begin
      unique case (op)
        OP_STOP: begin
          state_n    = IDLE;
          mask_n     = '0;
          switch_req = 1'b0;
          enter_req  = 1'b0;
        end
        OP_SELECT: begin
          enter_req = 1'b0;
          if (state == ON_STATIC && ch_idx == cmd_data[2:0]) begin
            switch_req = 1'b0;
          end else begin
            switch_req = 1'b1;
            sw_ch      = cmd_data[2:0];
            sw_scan    = 1'b0;
          end
        end
        OP_SET_DWELL: code_n = cmd_data[5:0];
        OP_SCAN: begin
          mask_n    = scan_mask;
          enter_req = 1'b0;
          if (scan_mask == '0) begin
            state_n    = IDLE;
            switch_req = 1'b0;
          end else begin
            switch_req = 1'b1;
            sw_ch      = next_set(scan_mask, 3'd7);
            sw_scan    = 1'b1;
          end
        end
      endcase
    end

    dwell_load = (DW'(code_n) << DWELL_SHIFT) + DW'((1 << DWELL_SHIFT) - 1);

    if (switch_req) begin
      enter_ch   = sw_ch;
      enter_scan = sw_scan;
    end

    if (switch_req && BBM_EN) begin
      state_n     = DEAD;
      dead_n      = DEAD_LOAD;
      pend_ch_n   = sw_ch;
      pend_scan_n = sw_scan;
    end else if (switch_req || enter_req) begin
      ch_n    = enter_ch;
      state_n = enter_scan ? ON_SCAN : ON_STATIC;
      if (enter_scan) dwell_n = dwell_load;
    end

    en_n   = (state_n == ON_STATIC || state_n == ON_SCAN) ? (8'b1 << ch_n) : '0;
    done_n = (state_n == ON_SCAN) && (dwell_n == '0);
    wrap_n = done_n && (ch_n == high_bit(mask_n));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dead_cnt    <= '0;
      dwell_cnt   <= '0;
      dwell_code  <= '0;
      mask        <= '0;
      pend_ch     <= '0;
      pend_scan   <= 1'b0;
      ch_idx      <= '0;
      amux_en     <= '0;
      amux_en_neg <= '1;
      busy        <= 1'b0;
      ch_done     <= 1'b0;
      scan_wrap   <= 1'b0;
    end else begin
      state       <= state_n;
      dead_cnt    <= dead_n;
      dwell_cnt   <= dwell_n;
      dwell_code  <= code_n;
      mask        <= mask_n;
      pend_ch     <= pend_ch_n;
      pend_scan   <= pend_scan_n;
      ch_idx      <= ch_n;
      amux_en     <= en_n;
      amux_en_neg <= ~en_n;
      busy        <= (state_n != IDLE);
      ch_done     <= done_n;
      scan_wrap   <= wrap_n;
    end
  end

endmodule

// File: tb/tb_amux_scan_ctrl.sv
// Self-checking bench for amux_scan_ctrl: directed scenarios plus random commands against
// a segment-timeline reference model (gap length follows AMUX_SCAN_BBM_EN).
module tb_amux_scan_ctrl;

  localparam int DWELL_SHIFT = 2;
  localparam int DEAD_CYCLES = 4;
`ifdef AMUX_SCAN_BBM_EN
  localparam int G = DEAD_CYCLES;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = '0;
  logic [7:0] scan_mask = '0;
  logic [7:0] amux_en, amux_en_neg;
  logic       busy, ch_done, scan_wrap;
  logic [2:0] ch_idx;

  amux_scan_ctrl #(.DWELL_SHIFT(DWELL_SHIFT), .DEAD_CYCLES(DEAD_CYCLES)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .scan_mask(scan_mask), .amux_en(amux_en), .amux_en_neg(amux_en_neg),
    .busy(busy), .ch_idx(ch_idx), .ch_done(ch_done), .scan_wrap(scan_wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 gap, 2 static, 3 scan; m_end is the absolute last cycle of a segment.
  longint     cyc = 0;
  int         m_mode = 0;
  int         m_ch = 0, m_tgt = 0;
  bit         m_tgt_scan = 0;
  longint     m_end = 0;
  int         m_code = 0;
  logic [7:0] m_mask = '0;
  logic [7:0] prev_en = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lowest(input logic [7:0] m);
    int r = 0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  function automatic int highest(input logic [7:0] m);
    int r = 0;
    for (int i = 0; i < 8; i++) if (m[i]) r = i;
    return r;
  endfunction

  function automatic int next_above(input logic [7:0] m, input int c);
    for (int k = 1; k <= 8; k++) if (m[(c + k) % 8]) return (c + k) % 8;
    return c;
  endfunction

  task automatic m_enter(input int c, input bit s, input longint t);
    m_mode = s ? 3 : 2;
    m_ch   = c;
    if (s) m_end = t + ((m_code + 1) << DWELL_SHIFT) - 1;
  endtask

  task automatic m_switch(input int c, input bit s, input longint t);
    if (G > 0) begin
      m_mode = 1; m_tgt = c; m_tgt_scan = s; m_end = t + G - 1;
    end else begin
      m_enter(c, s, t);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] d, input logic [7:0] sm);
    bit handled = 0;
    cyc++;
    if (r) begin
      m_mode = 0; m_ch = 0; m_code = 0; m_mask = '0;
      return;
    end
    if (v) begin
      case (d[7:6])
        2'b00: begin m_mode = 0; m_mask = '0; handled = 1; end
        2'b01: begin
          if (!(m_mode == 2 && m_ch == int'(d[2:0]))) m_switch(int'(d[2:0]), 0, cyc);
          handled = 1;
        end
        2'b10: m_code = int'(d[5:0]);
        default: begin
          m_mask = sm; handled = 1;
          if (sm == 0) m_mode = 0;
          else         m_switch(lowest(sm), 1, cyc);
        end
      endcase
    end
    if (!handled) begin
      if (m_mode == 1 && cyc > m_end)      m_enter(m_tgt, m_tgt_scan, cyc);
      else if (m_mode == 3 && cyc > m_end) m_switch(next_above(m_mask, m_ch), 1, cyc);
    end
  endtask

  task automatic tick();
    logic [7:0] e8, e8n;
    bit         e_done;
    @(posedge clk);
    model_step(rst, cmd_valid, cmd_data, scan_mask);
    @(negedge clk);
    e8     = (m_mode >= 2) ? (8'b1 << m_ch) : 8'h00;
    e8n    = ~e8;
    e_done = (m_mode == 3) && (cyc == m_end);
    check("amux_en", amux_en, e8);
    check("amux_en_neg", amux_en_neg, e8n);
    check("busy", busy, m_mode != 0);
    check("ch_idx", ch_idx, m_ch);
    check("ch_done", ch_done, e_done);
    check("scan_wrap", scan_wrap, e_done && (m_ch == highest(m_mask)));
    check("onehot", $countones(amux_en) <= 1, 1);
    if (G > 0 && !rst)
      check("bbm_adjacent", (prev_en != 0 && amux_en != 0 && prev_en != amux_en), 0);
    prev_en = amux_en;
  endtask

  task automatic do_cmd(input logic [7:0] d, input logic [7:0] m);
    cmd_valid = 1'b1; cmd_data = d; scan_mask = m;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [7:0] exp_q[$];
  int         n;
  int         chs[4] = '{0, 2, 7, 0};

  initial begin
    // Reset with command strobes held during reset
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_data = 8'h45; tick();
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_en", amux_en, 8'h00);
      check("idle_neg", amux_en_neg, 8'hFF);
      check("idle_busy", busy, 0);
    end

    // SELECT ch5: gap then 8'h20, repeat gives no gap
    do_cmd(8'h45, 8'h00);
    for (int i = 1; i <= G; i++) begin
      check("sel_gap", amux_en, 8'h00);
      tick();
    end
    check("sel_on", amux_en, 8'h20);
    for (int i = 0; i < 3; i++) tick();
    do_cmd(8'h45, 8'h00);
    check("sel_repeat", amux_en, 8'h20);
    check("sel_repeat_busy", busy, 1);
    tick();

    // SET_DWELL 0x80 then scan mask 1000_0101
    do_cmd(8'h80, 8'h00);
    do_cmd(8'hC0, 8'h85);
    exp_q.delete();
    for (int i = 0; i < G; i++) exp_q.push_back(8'h00);
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(8'b1 << chs[j]);
      if (j < 3) for (int i = 0; i < G; i++) exp_q.push_back(8'h00);
    end
    foreach (exp_q[i]) begin
      check("scan_seq", amux_en, exp_q[i]);
      tick();
    end

    // SCAN with empty mask
    do_cmd(8'hC0, 8'h00);
    check("scan0_busy", busy, 0);
    check("scan0_en", amux_en, 8'h00);
    tick();

    // Mid-dwell SET_DWELL during ch0
    do_cmd(8'hC0, 8'h85);
    for (int i = 0; i < G; i++) tick();
    check("mid_ch0_start", amux_en, 8'h01);
    do_cmd(8'h81, 8'h00);
    n = 1;
    while (amux_en == 8'h01 && n < 50) begin n++; tick(); end
    check("mid_ch0_len", n, 4);
    n = 0;
    while (amux_en == 8'h00 && n < 50) begin n++; tick(); end
    check("mid_gap_len", n, G);
    n = 0;
    while (amux_en == 8'h04 && n < 50) begin n++; tick(); end
    check("mid_ch2_len", n, 8);

    // STOP during gap and during ON
    do_cmd(8'h43, 8'h00);
    do_cmd(8'h00, 8'h00);
    check("stop_gap_en", amux_en, 8'h00);
    check("stop_gap_busy", busy, 0);
    do_cmd(8'h43, 8'h00);
    for (int i = 0; i < G + 2; i++) tick();
    check("stop_pre_on", amux_en, 8'h08);
    do_cmd(8'h00, 8'h00);
    check("stop_on_en", amux_en, 8'h00);
    check("stop_on_busy", busy, 0);
    tick();

    // Random command traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cmd_valid = ($urandom_range(0, 9) == 0);
      cmd_data  = 8'($urandom);
      if (cmd_data[7:6] == 2'b10) cmd_data[5:0] = 6'($urandom_range(0, 3));
      scan_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      tick();
    end
    rst = 1'b0; cmd_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
